reg_file: RTL

General-purpose register file for the multicycle CPU: 32 entries of 32 bits, two combinational read ports and one synchronous write port. Sits directly upstream of the A/B operand latches. Read port 1 feeds register A and read port 2 feeds register B, and both capture on the following clock edge. Writes come from the write-back step (ALUOut or MDR via the write-data mux), and register 0 is hardwired to zero.

---
 rtl/reg_file.sv | 57 +++++
 1 files changed

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational read ports, one write port, r0 = 0
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_live;

    // A write to r0 is dropped here, so mem[0] stays at its reset value.
    assign wr_live = rst && we && (wa != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wa] <= wd;
        end
    end

    // The reset gate also suppresses forwarding while rst is low.
    always_comb begin
        rd1 = mem[ra1];
        if (BYPASS && wr_live && (wa == ra1)) begin
            rd1 = wd;
        end
        if (!rst || (ra1 == '0)) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (BYPASS && wr_live && (wa == ra2)) begin
            rd2 = wd;
        end
        if (!rst || (ra2 == '0)) begin
            rd2 = '0;
        end
    end

endmodule
